pc_fetch_unit: RTL

- Program-counter and instruction-fetch stage.
- Holds the current PC and drives it to the registered PC+4 adder stage, then takes that stage's sequential address back in.
- Selects the next PC: sequential, branch redirect, or hold on stall.
- Issues one instruction-memory request at a time over a ready/valid handshake and forwards each returned instruction, tagged with its PC, to decode.

---
 rtl/pc_fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
// Holds the PC, exchanges it with an external registered PC+4 adder, issues
// one instruction-memory request at a time over ready/valid, and forwards each
// returned instruction (tagged with its PC) to decode. Branch redirects either
// retarget the PC directly (when no request is outstanding) or are remembered
// as pending so the in-flight response is thrown away.
module pc_fetch_unit #(
    parameter int                DATA_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_seq_addr,
    input  logic              i_branch_taken,
    input  logic [DATA_W-1:0] i_branch_target,
    input  logic              i_stall,
    input  logic              i_mem_ready,
    input  logic              i_mem_valid,
    input  logic [INST_W-1:0] i_mem_inst,
    output logic [DATA_W-1:0] o_pc,
    output logic              o_mem_req,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [DATA_W-1:0] o_inst_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] pc_reg, pc_next;
    logic              pend_reg, pend_next;
    logic [DATA_W-1:0] tgt_reg, tgt_next;
    logic              inst_valid_reg, inst_valid_next;
    logic [INST_W-1:0] inst_reg, inst_next;
    logic [DATA_W-1:0] inst_pc_reg, inst_pc_next;

    // Redirect targets are always word aligned; low two bits are dropped.
    logic [DATA_W-1:0] target_aligned;
    assign target_aligned = i_branch_target & ~DATA_W'(3);

    // State and datapath registers; reset abandons any outstanding fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            pend_reg       <= 1'b0;
            tgt_reg        <= '0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_reg       <= pend_next;
            tgt_reg        <= tgt_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
        end
    end

    // Next-state, PC selection, redirect bookkeeping and delivery.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_next       = pend_reg;
        tgt_next        = tgt_reg;
        inst_valid_next = 1'b0;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;

        case (state_reg)
            ST_IDLE: begin
                // Nothing in flight: a redirect retargets the PC directly.
                if (i_branch_taken) begin
                    pc_next = target_aligned;
                end
                state_next = i_stall ? ST_HOLD : ST_REQ;
            end

            ST_REQ: begin
                // The request is never withdrawn; a redirect here is
                // remembered so its response gets discarded.
                if (i_branch_taken) begin
                    pend_next = 1'b1;
                    tgt_next  = target_aligned;
                end
                if (i_mem_ready) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (i_mem_valid) begin
                    if (i_branch_taken) begin
                        // Redirect arriving with the response is the newest.
                        pc_next   = target_aligned;
                        pend_next = 1'b0;
                    end else if (pend_reg) begin
                        pc_next   = tgt_reg;
                        pend_next = 1'b0;
                    end else begin
                        inst_valid_next = 1'b1;
                        inst_next       = i_mem_inst;
                        inst_pc_next    = pc_reg;
                        // PC has been stable since REQ, so the adder output
                        // is already PC+4 here.
                        pc_next         = i_seq_addr;
                    end
                    state_next = i_stall ? ST_HOLD : ST_REQ;
                end else if (i_branch_taken) begin
                    pend_next = 1'b1;
                    tgt_next  = target_aligned;
                end
            end

            ST_HOLD: begin
                if (i_branch_taken) begin
                    pc_next = target_aligned;
                end
                if (!i_stall) begin
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_pc         = pc_reg;
    assign o_mem_req    = (state_reg == ST_REQ);
    assign o_mem_addr   = (state_reg == ST_REQ) ? pc_reg : '0;
    assign o_inst_valid = inst_valid_reg;
    assign o_inst       = inst_reg;
    assign o_inst_pc    = inst_pc_reg;

endmodule
